// File: rtl/dpi_importer_pkg.sv
// Shared types and default sizing for the DPI importer sink.
//   DEF_*   : default parameter values, mirrored by the top-level parameters
//   ID_W    : request id width (one extra MSB so out-of-range ids can be expressed)
//   state_e : apply-engine states
//   req_t   : buffered write request at the default sizing
package dpi_importer_pkg;

    localparam int unsigned DEF_NUM_SIG    = 8;
    localparam int unsigned DEF_DATA_W     = 64;
    localparam int unsigned DEF_FIFO_DEPTH = 4;
    localparam int unsigned DEF_DLY_W      = 8;
    localparam int unsigned ID_W           = $clog2(DEF_NUM_SIG) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        APPLY = 2'd2
    } state_e;

    typedef struct packed {
        logic [ID_W-1:0]       id;
        logic [DEF_DATA_W-1:0] data;
        logic [DEF_DLY_W-1:0]  delay;
    } req_t;

endpackage

// File: rtl/dpi_importer_fifo.sv
// Synchronous request FIFO with asynchronous active-low reset.
// Ports:
//   clock, reset     : clock, async active-low reset (flushes pointers)
//   push, push_data  : write request; ignored while full
//   pop              : drop the head entry; ignored while empty
//   head             : current head entry (valid when !empty)
//   full, empty      : occupancy flags
// Pointers carry one extra wrap bit so full/empty come from a plain compare.
module dpi_importer_fifo
    import dpi_importer_pkg::*;
#(
    parameter type         item_t = req_t,
    parameter int unsigned DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  push,
    input  item_t push_data,
    input  logic  pop,
    output item_t head,
    output logic  full,
    output logic  empty
);

    localparam int unsigned AddrW = $clog2(DEPTH);
    localparam int unsigned PtrW  = AddrW + 1;

    item_t            mem [DEPTH];
    logic [PtrW-1:0]  wr_q;
    logic [PtrW-1:0]  rd_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[PtrW-1] != rd_q[PtrW-1]) &&
                     (wr_q[AddrW-1:0] == rd_q[AddrW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_q[AddrW-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PtrW'(1);
            if (do_pop)  rd_q <= rd_q + PtrW'(1);
        end
    end

    // Storage needs no reset: entries are only read once the pointers say so.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_q[AddrW-1:0]] <= push_data;
    end

endmodule

// File: rtl/dpi_importer_sink.sv
// Applies verification-side writes (id, value, delay) to per-signal registers.
// Requests are buffered in order; each waits its programmed delay, then is
// written to its signal register with a one-cycle update strobe.
// Ports:
//   clock, reset          : clock, async active-low reset
//   req_valid/req_ready   : request handshake (ready = !full)
//   req_id/data/delay     : target signal, value, idle cycles before the write
//   out_values            : signal k at [k*DATA_W +: DATA_W]
//   out_update            : one-hot pulse for the signal written this cycle
//   busy                  : FIFO non-empty or engine not idle
//   err_bad_id            : sticky, a request with id >= NUM_SIG was dropped
module dpi_importer_sink
    import dpi_importer_pkg::*;
#(
    parameter int unsigned       NUM_SIG    = DEF_NUM_SIG,
    parameter int unsigned       DATA_W     = DEF_DATA_W,
    parameter int unsigned       FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned       DLY_W      = DEF_DLY_W,
    parameter logic [DATA_W-1:0] RESET_VAL  = '0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [$clog2(NUM_SIG):0]  req_id,
    input  logic [DATA_W-1:0]         req_data,
    input  logic [DLY_W-1:0]          req_delay,
    output logic [NUM_SIG*DATA_W-1:0] out_values,
    output logic [NUM_SIG-1:0]        out_update,
    output logic                      busy,
    output logic                      err_bad_id
);

    localparam int unsigned IdW = $clog2(NUM_SIG) + 1;

    typedef struct packed {
        logic [IdW-1:0]    id;
        logic [DATA_W-1:0] data;
        logic [DLY_W-1:0]  delay;
    } item_t;

    state_e                           state_q, state_d;
    logic [DLY_W-1:0]                 cnt_q, cnt_d;
    logic [NUM_SIG-1:0][DATA_W-1:0]   values_q;
    logic [NUM_SIG-1:0]               update_q;
    logic                             err_q;

    logic                             push;
    item_t                            push_item;
    logic                             pop;
    item_t                            head;
    logic                             full;
    logic                             empty;
    logic                             apply;
    logic [NUM_SIG-1:0]               hit;

    assign push      = req_valid;
    assign push_item = '{id: req_id, data: req_data, delay: req_delay};
    assign req_ready = !full;

    dpi_importer_fifo #(
        .item_t (item_t),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_item),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    // Apply engine: IDLE loads the head delay, WAIT counts it down, APPLY
    // writes and pops. A delay of d spends exactly d cycles in WAIT.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    cnt_d   = head.delay;
                    state_d = (head.delay == '0) ? APPLY : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - DLY_W'(1);
                if (cnt_q == DLY_W'(1)) state_d = APPLY;
            end
            APPLY: begin
                pop     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign apply = (state_q == APPLY);

    // One-hot target decode; all-zero means the id is out of range.
    always_comb begin
        hit = '0;
        for (int unsigned k = 0; k < NUM_SIG; k++) begin
            hit[k] = (head.id == IdW'(k));
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            values_q <= {NUM_SIG{RESET_VAL}};
            update_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            update_q <= apply ? hit : '0;
            if (apply && (hit == '0)) err_q <= 1'b1;
            for (int unsigned k = 0; k < NUM_SIG; k++) begin
                if (apply && hit[k]) values_q[k] <= head.data;
            end
        end
    end

    assign out_values = values_q;
    assign out_update = update_q;
    assign err_bad_id = err_q;
    assign busy       = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_dpi_importer_sink.sv
// Self-checking bench for dpi_importer_sink: directed scenarios plus a random
// request stream, checked every cycle against a timeline model of the queue.
module tb_dpi_importer_sink;

    localparam int NUM_SIG    = 8;
    localparam int DATA_W     = 64;
    localparam int FIFO_DEPTH = 4;
    localparam int DLY_W      = 8;
    localparam int ID_W       = 4;
    localparam int VW         = NUM_SIG * DATA_W;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ID_W-1:0]   req_id = '0;
    logic [DATA_W-1:0] req_data = '0;
    logic [DLY_W-1:0]  req_delay = '0;
    logic [VW-1:0]     out_values;
    logic [NUM_SIG-1:0] out_update;
    logic              busy;
    logic              err_bad_id;

    dpi_importer_sink #(
        .NUM_SIG    (NUM_SIG),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .DLY_W      (DLY_W),
        .RESET_VAL  ('0)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_id     (req_id),
        .req_data   (req_data),
        .req_delay  (req_delay),
        .out_values (out_values),
        .out_update (out_update),
        .busy       (busy),
        .err_bad_id (err_bad_id)
    );

    always #5 clock = ~clock;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int upd3    = 0;

    // Model: each accepted request is written 2+delay edges after the later of
    // its accept edge and the previous write edge.
    typedef struct {
        int          id;
        logic [63:0] data;
        int          dly;
        int          acc;
    } mreq_t;

    mreq_t       mq[$];
    logic [63:0] m_val[NUM_SIG];
    int          m_upd = -1;
    bit          m_err = 1'b0;
    int          next_free = 0;

    task automatic check_eq(input string tag, input logic [VW-1:0] got,
                            input logic [VW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int k = 0; k < NUM_SIG; k++) m_val[k] = '0;
        m_upd     = -1;
        m_err     = 1'b0;
        next_free = cyc;
    endtask

    task automatic model_edge(input bit v, input int id, input logic [63:0] data,
                              input int dly, output bit acc);
        int s;
        acc   = v && (mq.size() < FIFO_DEPTH);
        m_upd = -1;
        if (mq.size() > 0) begin
            s = (mq[0].acc > next_free) ? mq[0].acc : next_free;
            if (cyc == s + 2 + mq[0].dly) begin
                if (mq[0].id < NUM_SIG) begin
                    m_val[mq[0].id] = mq[0].data;
                    m_upd           = mq[0].id;
                end else begin
                    m_err = 1'b1;
                end
                void'(mq.pop_front());
                next_free = cyc;
            end
        end
        if (acc) mq.push_back('{id: id, data: data, dly: dly, acc: cyc});
    endtask

    task automatic compare_all();
        logic [VW-1:0]      ev;
        logic [NUM_SIG-1:0] eu;
        for (int k = 0; k < NUM_SIG; k++) ev[k*DATA_W +: DATA_W] = m_val[k];
        eu = '0;
        if (m_upd >= 0) eu[m_upd] = 1'b1;
        check_eq("req_ready", VW'(req_ready), VW'(mq.size() < FIFO_DEPTH));
        check_eq("busy", VW'(busy), VW'(mq.size() > 0));
        check_eq("out_update", VW'(out_update), VW'(eu));
        check_eq("err_bad_id", VW'(err_bad_id), VW'(m_err));
        check_eq("out_values", out_values, ev);
    endtask

    // Called just after a rising edge; drives one cycle of input and checks.
    task automatic step(input bit v, input int id, input logic [63:0] data,
                        input int dly, output bit acc);
        req_valid = v;
        req_id    = ID_W'(id);
        req_data  = data;
        req_delay = DLY_W'(dly);
        @(posedge clock);
        cyc++;
        model_edge(v, id, data, dly, acc);
        #1;
        compare_all();
        if (out_update[3]) upd3++;
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit a;
        repeat (n) step(1'b0, 0, '0, 0, a);
    endtask

    task automatic push(input int id, input logic [63:0] data, input int dly);
        bit a = 1'b0;
        for (int t = 0; t < 32 && !a; t++) step(1'b1, id, data, dly, a);
        check_eq("push_accepted", VW'(a), VW'(1));
    endtask

    task automatic reset_checks(input string tag);
        check_eq({tag, "_values"}, out_values, '0);
        check_eq({tag, "_update"}, VW'(out_update), '0);
        check_eq({tag, "_busy"}, VW'(busy), '0);
        check_eq({tag, "_err"}, VW'(err_bad_id), '0);
        check_eq({tag, "_ready"}, VW'(req_ready), VW'(1));
    endtask

    // Asynchronous reset in the middle of a cycle, held across one edge.
    task automatic do_reset();
        req_valid = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        reset_checks("async_rst");
        model_reset();
        @(posedge clock);
        cyc++;
        #1;
        reset_checks("held_rst");
        #2;
        reset = 1'b1;
        next_free = cyc;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin : main
        logic [VW-1:0] ev;
        bit            a;
        int            id;
        int            dly;
        int            guard;

        model_reset();
        #2;
        reset_checks("por");
        #10;
        reset = 1'b1;
        idle(1);

        // Single delay-0 write lands two edges after acceptance.
        push(2, 64'hDEAD_BEEF, 0);
        idle(2);
        ev = '0;
        ev[2*DATA_W +: DATA_W] = 64'hDEAD_BEEF;
        check_eq("t1_values", out_values, ev);
        check_eq("t1_update", VW'(out_update), VW'(8'b0000_0100));
        idle(1);

        // Delay 3: write after accept edge + 5.
        push(5, 64'h1234, 3);
        idle(4);
        check_eq("t2_pre_update", VW'(out_update), '0);
        check_eq("t2_busy_pre", VW'(busy), VW'(1));
        idle(1);
        check_eq("t2_update", VW'(out_update), VW'(8'b0010_0000));
        check_eq("t2_val5", VW'(out_values[5*DATA_W +: DATA_W]), VW'(64'h1234));

        // Back-to-back burst of five delay-0 writes.
        for (int i = 0; i < 5; i++) push(i + 1, 64'(32'hA000 + i), 0);
        idle(12);

        // Repeated writes to one id: three pulses, last value wins.
        upd3 = 0;
        push(3, 64'h1, 0);
        push(3, 64'h2, 0);
        push(3, 64'h3, 0);
        idle(8);
        check_eq("t4_pulses", VW'(upd3), VW'(3));
        check_eq("t4_val3", VW'(out_values[3*DATA_W +: DATA_W]), VW'(64'h3));

        // Out-of-range id: dropped, sticky error, later writes still apply.
        push(9, 64'hBAD, 0);
        idle(3);
        check_eq("t5_err", VW'(err_bad_id), VW'(1));
        push(1, 64'h55, 0);
        idle(3);
        check_eq("t5_val1", VW'(out_values[1*DATA_W +: DATA_W]), VW'(64'h55));
        check_eq("t5_err_sticky", VW'(err_bad_id), VW'(1));

        // Reset during the 4th WAIT cycle of a delay-10 request.
        push(6, 64'hCAFE, 10);
        idle(4);
        check_eq("t6_busy", VW'(busy), VW'(1));
        do_reset();
        idle(16);
        check_eq("t6_val6", VW'(out_values[6*DATA_W +: DATA_W]), '0);

        // Random stream with one reset in the middle.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            id  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 15))
                                              : int'($urandom_range(0, 7));
            dly = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 12))
                                              : int'($urandom_range(0, 3));
            step($urandom_range(0, 99) < 55, id, {$urandom, $urandom}, dly, a);
        end
        guard = 0;
        while (mq.size() > 0 && guard < 200) begin
            idle(1);
            guard++;
        end
        idle(1);
        check_eq("drained_busy", VW'(busy), '0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
